gate_resp_checker: RTL

Synthesizable response checker for two-input universal-gate test benches. It accepts one `{a,b}` stimulus vector at a time, waits a programmable settling interval, then samples the gate-under-test output and compares it against a parameterised truth table. It accumulates a mismatch count, per-vector coverage and a sticky fail flag. It sits downstream of the stimulus driver and beside the gate under test, so gate correctness is judged in hardware rather than by waveform inspection.

---
 rtl/gate_resp_checker.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/gate_resp_checker.sv
// Response checker for a two-input gate: accepts {a,b}, waits SETTLE cycles, samples dut_out against TRUTH.
// Optional first-mismatch capture port enabled by defining GATE_CHK_FIRSTFAIL_EN.
module gate_resp_checker #(
    parameter logic [3:0]  TRUTH  = 4'b0001,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             dut_out,
    output logic             in_ready,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       cov,
    output logic             all_cov,
    output logic             fail
`ifdef GATE_CHK_FIRSTFAIL_EN
    ,
    output logic [2:0]       first_fail
`endif
);

    localparam int unsigned        SCNT_W    = 4;
    localparam logic [SCNT_W-1:0]  SETTLE_LD = (SETTLE == 0) ? '0 : SCNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SCNT_W-1:0] cnt;
    logic [1:0]        vec;
    logic              accept;
    logic              sample;
    logic              cnt_dec;
    logic              exp_bit;
    logic              mismatch;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; clr overrides every transition
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_nxt = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        state_nxt = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // Per-state strobes driving the datapath
    always_comb begin
        accept  = 1'b0;
        sample  = 1'b0;
        cnt_dec = 1'b0;
        if (!clr) begin
            case (state)
                ST_IDLE:   accept  = in_valid;
                ST_SETTLE: cnt_dec = (cnt != '0);
                ST_SAMPLE: sample  = 1'b1;
                default:   accept  = 1'b0;
            endcase
        end
    end

    assign exp_bit  = TRUTH[vec];
    assign mismatch = (dut_out != exp_bit);
    assign all_cov  = &cov;

    // Captured vector, settle counter, result and statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec        <= '0;
            cnt        <= '0;
            in_ready   <= 1'b1;
            chk_valid  <= 1'b0;
            chk_pass   <= 1'b0;
            err_cnt    <= '0;
            cov        <= '0;
            fail       <= 1'b0;
`ifdef GATE_CHK_FIRSTFAIL_EN
            first_fail <= '0;
`endif
        end else begin
            in_ready  <= (state_nxt == ST_IDLE);
            chk_valid <= sample;
            if (accept) begin
                vec <= {in_b, in_a};
                cnt <= SETTLE_LD;
            end else if (cnt_dec) begin
                cnt <= cnt - SCNT_W'(1);
            end
            if (clr) begin
                err_cnt    <= '0;
                cov        <= '0;
                fail       <= 1'b0;
`ifdef GATE_CHK_FIRSTFAIL_EN
                first_fail <= '0;
`endif
            end else if (sample) begin
                chk_pass <= !mismatch;
                cov[vec] <= 1'b1;
                if (mismatch) begin
                    if (err_cnt != '1) begin
                        err_cnt <= err_cnt + CNT_W'(1);
                    end
                    fail <= 1'b1;
`ifdef GATE_CHK_FIRSTFAIL_EN
                    // fail doubles as "first mismatch already recorded"
                    if (!fail) begin
                        first_fail <= {vec, dut_out};
                    end
`endif
                end
            end
        end
    end

endmodule
